// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, instruction
// size and the layout of one fetch-buffer entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int INST_BYTES = 4;
  localparam int INST_W     = 32;
  localparam int PC_W       = 64;

  // Entry layout as stored in the fetch buffer: pc in the upper bits.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with push/pop/flush. Flush wins over push and pop.
// A push into a full buffer is accepted only when a pop frees a slot the same
// cycle. Storage is cleared on reset so the head reads zero before any fetch.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, addresses instruction memory
// combinationally and buffers {pc, instruction} pairs toward IF/ID.
// Optional feature macro FETCH_BOUND_CHECK_EN: halts fetch once the PC leaves
// the program image (pc >= IMEM_BYTES) until a redirect restarts it.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                    PC_WIDTH   = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                    IMEM_BYTES = 88,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [PC_WIDTH-1:0] inst_address,
  input  logic [INST_W-1:0]   instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [INST_W-1:0]   out_inst,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted
);

  localparam logic [PC_WIDTH-1:0] IMEM_LIMIT = PC_WIDTH'(IMEM_BYTES);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(INST_BYTES);

  fetch_state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]          pc, pc_nxt;
  logic                         push, pop, flush;
  logic                         fifo_full, fifo_empty;
  logic                         in_range, bound_ok;
  logic [PC_WIDTH+INST_W-1:0]   head;

  assign in_range = (pc < IMEM_LIMIT);

`ifdef FETCH_BOUND_CHECK_EN
  assign bound_ok = in_range;
  assign halted   = (state == HALT);
`else
  logic unused_in_range;
  assign unused_in_range = in_range;
  assign bound_ok        = 1'b1;
  assign halted          = 1'b0;
`endif

  assign inst_address       = pc;
  assign out_valid          = !fifo_empty;
  assign {out_pc, out_inst} = head;

  // State and PC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next state, next PC and buffer controls; a redirect overrides everything
  // except in IDLE, where it is ignored.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    if (redirect && state != IDLE) begin
      flush     = 1'b1;
      state_nxt = RUN;
      pc_nxt    = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    end else begin
      pop = !fifo_empty && out_ready;
      case (state)
        IDLE: if (start) state_nxt = RUN;
        RUN: begin
          if (!bound_ok) begin
            state_nxt = HALT;
          end else if (!fifo_full || pop) begin
            push   = 1'b1;
            pc_nxt = pc + PC_STEP;
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PC_WIDTH + INST_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({pc, instruction}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
